// File: rtl/mult8x8_ctrl.sv
// Sequencer for an 8x8 multiply built from four 4x4 partial products.
// Drives nibble selects, shift and accumulator enables; Moore, registered outputs.
module mult8x8_ctrl (
  input  logic       clk,
  input  logic       aclr_n,
  input  logic       start,
  output logic       sel_a,
  output logic       sel_b,
  output logic [1:0] shift,
  output logic       clk_ena,
  output logic       sclr_n,
  output logic [1:0] count_out,
  output logic [1:0] state_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] count_q, count_d;

  logic       sel_a_q, sel_a_d;
  logic       sel_b_q, sel_b_d;
  logic [1:0] shift_q, shift_d;
  logic       ena_q, ena_d;
  logic       sclr_n_q, sclr_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = 2'd0;
        if (start) state_d = CALC;
      end
      CALC: begin
        if (start) begin
          state_d = ERR;
          count_d = 2'd0;
        end else if (count_q == 2'd3) begin
          state_d = DONE;
          count_d = 2'd0;
        end else begin
          count_d = count_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = 2'd0;
      end
      ERR: begin
        count_d = 2'd0;
        if (!start) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = 2'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registers hold
  // exactly the decode of state_q/count_q in every cycle.
  always_comb begin
    sel_a_d  = 1'b0;
    sel_b_d  = 1'b0;
    shift_d  = 2'd0;
    ena_d    = 1'b0;
    sclr_n_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (1'b1)
      (state_d == CALC): begin
        busy_d = 1'b1;
        ena_d  = 1'b1;
        case (count_d)
          2'd0: sclr_n_d = 1'b0;
          2'd1: begin
            sel_b_d = 1'b1;
            shift_d = 2'd1;
          end
          2'd2: begin
            sel_a_d = 1'b1;
            shift_d = 2'd1;
          end
          default: begin
            sel_a_d = 1'b1;
            sel_b_d = 1'b1;
            shift_d = 2'd2;
          end
        endcase
      end
      (state_d == DONE): done_d = 1'b1;
      (state_d == ERR):  err_d  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= IDLE;
      count_q  <= 2'd0;
      sel_a_q  <= 1'b0;
      sel_b_q  <= 1'b0;
      shift_q  <= 2'd0;
      ena_q    <= 1'b0;
      sclr_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      shift_q  <= shift_d;
      ena_q    <= ena_d;
      sclr_n_q <= sclr_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign shift     = shift_q;
  assign clk_ena   = ena_q;
  assign sclr_n    = sclr_n_q;
  assign count_out = count_q;
  assign state_out = state_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
